mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a one-entry output register.
// The winner's data is selected through a 4:1 mux, captured on grant, and
// held until the consumer takes it. A drain and a new capture can happen on
// the same edge, so a steady stream moves one word per cycle.

// 4:1 data mux, select 0..3 picks d0..d3.
module mux4_rr_arbiter_mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  // Plain select; every encoding is covered so no latch is possible.
  always_comb begin
    unique case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       out_src_q;

  logic [1:0]       win_idx;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  // Round-robin search starting at ptr: walk offsets high to low so the
  // smallest offset with a request is the one left in win_idx.
  always_comb begin
    logic [1:0] idx;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) win_idx = idx;
    end
  end

  // Capture whenever someone asks and the register is free or being drained.
  // rst_n gates it so no grant escapes while reset is held.
  assign load  = rst_n && (|req) && ((state_q == EMPTY) || out_ready);
  assign ptr_d = win_idx + 2'd1;

  // Grant is the one-hot winner on a capturing cycle, otherwise zero.
  always_comb begin
    gnt = 4'b0000;
    if (load) gnt[win_idx] = 1'b1;
  end

  mux4_rr_arbiter_mux4 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (win_idx),
    .d0_i  (a),
    .d1_i  (b),
    .d2_i  (c),
    .d3_i  (d),
    .y_o   (mux_y)
  );

  // Output-register FSM: capture on load, empty on a drain with no new
  // request, otherwise hold. ptr moves only when something is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ptr_q     <= 2'd0;
      out_q     <= '0;
      out_src_q <= 2'd0;
    end else if (load) begin
      out_q     <= mux_y;
      out_src_q <= win_idx;
      ptr_q     <= ptr_d;
      state_q   <= FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_q   <= EMPTY;
    end
  end

  assign out       = out_q;
  assign out_src   = out_src_q;
  assign out_valid = (state_q == FULL);

endmodule
